// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: packs an MSB-first byte stream into 32-bit words and writes them
// to consecutive addresses from 0, holding the CPU off until the load finishes.
module instr_mem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Start,
  input  logic [8:0]        i_WordCount,
  input  logic              i_ByteValid,
  input  logic [7:0]        i_ByteData,
  output logic              o_ByteReady,
  output logic              o_WriteEnable,
  output logic [ADDR_W-1:0] o_WriteAddress,
  output logic [31:0]       o_WriteData,
  output logic              o_CpuHold,
  output logic              o_Done
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  state_t              r_state, w_next;
  logic [8:0]          r_n, r_idx;
  logic [1:0]          r_cnt;
  logic [23:0]         r_shift;
  logic [ADDR_W-1:0]   r_waddr;
  logic [31:0]         r_wdata;

  logic                w_accept;
  logic [8:0]          w_n;
  logic [8:0]          w_idx_inc;

  assign w_accept  = (r_state == RECV) && i_ByteValid;
  assign w_n       = (i_WordCount > DEPTH_W) ? DEPTH_W : i_WordCount;
  assign w_idx_inc = r_idx + 9'd1;

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_Start) w_next = (w_n == 9'd0) ? DONE : RECV;
      RECV:    if (w_accept && r_cnt == 2'd3) w_next = WRITE;
      WRITE:   w_next = (w_idx_inc == r_n) ? DONE : RECV;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The 4th byte bypasses the shifter and lands straight in the write-data register,
  // so address/data are ready exactly during the WRITE cycle and hold afterwards.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_n     <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_Start) begin
          r_n   <= w_n;
          r_idx <= '0;
          r_cnt <= '0;
        end
        RECV: if (w_accept) begin
          r_shift <= {r_shift[15:0], i_ByteData};
          r_cnt   <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_wdata <= {r_shift, i_ByteData};
            r_waddr <= ADDR_W'(r_idx);
          end
        end
        WRITE: begin
          r_idx <= w_idx_inc;
          r_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_ByteReady    = (r_state == RECV);
  assign o_WriteEnable  = (r_state == WRITE);
  assign o_CpuHold      = (r_state != IDLE);
  assign o_Done         = (r_state == DONE);
  assign o_WriteAddress = r_waddr;
  assign o_WriteData    = r_wdata;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: directed byte streams push expected writes/Done pulses,
// a negedge monitor pops and compares whenever the loader presents them.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_Start;
  logic [8:0]  i_WordCount;
  logic        i_ByteValid;
  logic [7:0]  i_ByteData;
  logic        o_ByteReady;
  logic        o_WriteEnable;
  logic [31:0] o_WriteAddress;
  logic [31:0] o_WriteData;
  logic        o_CpuHold;
  logic        o_Done;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  exp_done = 0;
  int  checks   = 0;
  int  errors   = 0;
  int  acc_cnt  = 0;

  instr_mem_loader #(.DEPTH(256), .ADDR_W(32)) dut (
    .i_Clock       (clk),
    .i_Reset       (rst_n),
    .i_Start       (i_Start),
    .i_WordCount   (i_WordCount),
    .i_ByteValid   (i_ByteValid),
    .i_ByteData    (i_ByteData),
    .o_ByteReady   (o_ByteReady),
    .o_WriteEnable (o_WriteEnable),
    .o_WriteAddress(o_WriteAddress),
    .o_WriteData   (o_WriteData),
    .o_CpuHold     (o_CpuHold),
    .o_Done        (o_Done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard; every Done must be expected.
  always @(negedge clk) begin
    if (o_WriteEnable) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", o_WriteAddress, o_WriteData);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        if (o_WriteAddress !== e.addr || o_WriteData !== e.data || o_ByteReady !== 1'b0) begin
          errors++;
          $display("FAIL write: got addr %h data %h rdy %b expected addr %h data %h rdy 0",
                   o_WriteAddress, o_WriteData, o_ByteReady, e.addr, e.data);
        end
      end
    end
    if (o_Done) begin
      checks++;
      if (exp_done <= 0 || o_CpuHold !== 1'b1) begin
        errors++;
        $display("FAIL done_pulse: got done with hold %b, pending %0d expected hold 1 pending>0",
                 o_CpuHold, exp_done);
      end else exp_done--;
    end
  end

  always @(posedge clk) if (i_ByteValid && o_ByteReady) acc_cnt++;

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = 32'(a);
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Start pulse with a byte presented in the same IDLE cycle (must not be consumed).
  task automatic start(input logic [8:0] n);
    @(negedge clk);
    i_Start = 1'b1; i_WordCount = n; i_ByteValid = 1'b1; i_ByteData = 8'hEE;
    @(negedge clk);
    i_Start = 1'b0; i_WordCount = 9'h1FF; i_ByteValid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      i_ByteValid = 1'b1; i_ByteData = b;
      if (o_ByteReady) begin
        @(posedge clk);
        ok = 1'b1;
      end
    end
    if (!ok) chk("byte_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (!o_CpuHold) ok = 1'b1;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    int          acc0;
    rst_n = 1'b0; i_Start = 1'b0; i_WordCount = '0; i_ByteValid = 1'b0; i_ByteData = '0;
    #23;
    chk("rst_outputs", {o_ByteReady, o_WriteEnable, o_CpuHold, o_Done}, 32'd0);
    chk("rst_addr", o_WriteAddress, 32'd0);
    chk("rst_data", o_WriteData, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hold", {31'd0, o_CpuHold}, 32'd0);

    // 1: two words, back-to-back bytes, exact latency
    push_wr(0, 32'h0801001A); push_wr(1, 32'h081F004C); exp_done++;
    start(9'd2);
    chk("t1_hold_after_start", {31'd0, o_CpuHold}, 32'd1);
    send_word(32'h0801001A);
    send_word(32'h081F004C);
    @(negedge clk); i_ByteValid = 1'b0;
    chk("t1_we_lat", {31'd0, o_WriteEnable}, 32'd1);
    chk("t1_hold_we", {31'd0, o_CpuHold}, 32'd1);
    @(negedge clk);
    chk("t1_done_lat", {30'd0, o_Done, o_CpuHold}, 32'd3);
    @(negedge clk);
    chk("t1_released", {30'd0, o_Done, o_CpuHold}, 32'd0);
    chk("t1_addr_hold", o_WriteAddress, 32'd1);
    chk("t1_data_hold", o_WriteData, 32'h081F004C);

    // 2: N=0 goes straight to Done
    exp_done++;
    start(9'd0);
    chk("t2_done", {30'd0, o_Done, o_ByteReady}, 32'd2);
    chk("t2_no_we", {31'd0, o_WriteEnable}, 32'd0);
    @(negedge clk);
    chk("t2_idle", {30'd0, o_CpuHold, o_ByteReady}, 32'd0);

    // 3: N=1 with ByteValid toggling, junk bytes while invalid
    push_wr(0, 32'hDEADBEEF); exp_done++;
    start(9'd1);
    w = 32'hDEADBEEF;
    for (int k = 3; k >= 0; k--) begin
      send_byte(w[k*8 +: 8]);
      @(negedge clk); i_ByteValid = 1'b0; i_ByteData = 8'h55;
    end
    wait_idle("t3_idle");
    chk("t3_queue_empty", 32'(sb_q.size()), 32'd0);

    // 4: N=300 clamps to 256 words; surplus bytes refused
    for (int i = 0; i < 256; i++)
      push_wr(i, {8'(i), ~8'(i), 8'hA5, 8'(i * 3)});
    exp_done++;
    acc0 = acc_cnt;
    start(9'd300 - 9'd44 + 9'd44);
    for (int i = 0; i < 256; i++) send_word({8'(i), ~8'(i), 8'hA5, 8'(i * 3)});
    wait_idle("t4_idle");
    repeat (6) begin
      @(negedge clk);
      chk("t4_surplus_ready", {31'd0, o_ByteReady}, 32'd0);
    end
    i_ByteValid = 1'b0;
    chk("t4_accepted", 32'(acc_cnt - acc0), 32'd1024);
    chk("t4_last_addr", o_WriteAddress, 32'd255);
    chk("t4_queue_empty", 32'(sb_q.size()), 32'd0);

    // 5: reset mid-word discards the partial word
    push_wr(0, 32'h11111111); push_wr(1, 32'h22222222); push_wr(2, 32'h33333333);
    start(9'd5);
    send_word(32'h11111111); send_word(32'h22222222); send_word(32'h33333333);
    send_byte(8'h44); send_byte(8'h44);
    @(negedge clk); i_ByteValid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outputs", {o_ByteReady, o_WriteEnable, o_CpuHold, o_Done}, 32'd0);
    chk("t5_rst_addr", o_WriteAddress, 32'd0);
    chk("t5_rst_data", o_WriteData, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    push_wr(0, 32'hCAFEF00D); exp_done++;
    start(9'd1);
    send_word(32'hCAFEF00D);
    @(negedge clk); i_ByteValid = 1'b0;
    wait_idle("t5_idle");

    // 6: Start during RECV with a different count is ignored
    push_wr(0, 32'hA0A1A2A3); push_wr(1, 32'hB0B1B2B3); exp_done++;
    start(9'd2);
    send_word(32'hA0A1A2A3);
    @(negedge clk); i_ByteValid = 1'b0;
    @(negedge clk);
    chk("t6_in_recv", {30'd0, o_ByteReady, o_CpuHold}, 32'd3);
    i_Start = 1'b1; i_WordCount = 9'd5;
    @(negedge clk); i_Start = 1'b0;
    send_word(32'hB0B1B2B3);
    @(negedge clk); i_ByteValid = 1'b0;
    wait_idle("t6_idle");
    repeat (8) @(negedge clk);
    chk("t6_stays_idle", {31'd0, o_CpuHold}, 32'd0);

    chk("final_queue_empty", 32'(sb_q.size()), 32'd0);
    chk("final_done_pending", 32'(exp_done), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
